weight_fetch_seq: RTL and testbench

Sequencer directly downstream of the per-unit pointer array. Walks the kernel round by round: one read per active unit per kernel index, then one bias read per active unit. Pulses `step` back to the pointer array between rounds. Routes in-order memory responses to the PE weight/bias registers, tagged with the destination unit.

---
 rtl/weight_fetch_seq.sv | 194 +++++++++++++++++++
 tb/tb_weight_fetch_seq.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_seq.sv
// Kernel weight/bias fetch sequencer: walks active units round by round, pulses
// step to the pointer array, and routes in-order read responses to PE registers.
module weight_fetch_seq #(
  parameter int N_UNITS = 16,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [7:0]                        kernel_size,
  input  logic [N_UNITS-1:0]                active_units,
  input  logic [N_UNITS-1:0][31:0]          addr_in,
  input  logic [N_UNITS-1:0][31:0]          bias_addr_in,
  output logic                              step,
  output logic                              mem_req,
  output logic [31:0]                       mem_addr,
  input  logic                              mem_ready,
  input  logic                              mem_rvalid,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              wr_valid,
  output logic [$clog2(N_UNITS)-1:0]        wr_unit,
  output logic                              wr_is_bias,
  output logic [DATA_W-1:0]                 wr_data,
  output logic                              busy,
  output logic                              done,
  output logic                              err
);

  localparam int UW = $clog2(N_UNITS);
  localparam int PW = $clog2(MAX_OUT);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, FETCH_W, FETCH_B, DRAIN, DONE} state_t;

  state_t              state_r;
  logic [7:0]          ks_r;
  logic [7:0]          k_r;
  logic [N_UNITS-1:0]  mask_r;
  logic [UW-1:0]       u_r;
  logic                hold_r;
  logic [31:0]         mem_addr_r;
  logic [UW:0]         fifo_r [MAX_OUT];
  logic [PW-1:0]       wptr_r;
  logic [PW-1:0]       rptr_r;
  logic [CW-1:0]       count_r;
  logic                wr_valid_r;
  logic [UW-1:0]       wr_unit_r;
  logic                wr_is_bias_r;
  logic [DATA_W-1:0]   wr_data_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;

  logic                issue_s;
  logic                accept_s;
  logic                pop_s;
  logic                step_s;
  logic                is_bias_s;
  logic [UW:0]         nxt_s;
  logic [UW-1:0]       first_u_s;
  logic [31:0]         req_addr_s;

  function automatic logic [UW-1:0] lowest_set(input logic [N_UNITS-1:0] m);
    lowest_set = '0;
    for (int i = N_UNITS - 1; i >= 0; i--)
      if (m[i]) lowest_set = UW'(i);
  endfunction

  // {found, index} of the lowest set bit strictly above u
  function automatic logic [UW:0] next_set(input logic [N_UNITS-1:0] m, input logic [UW-1:0] u);
    next_set = '0;
    for (int i = N_UNITS - 1; i >= 0; i--)
      if (m[i] && (i > int'(u))) next_set = {1'b1, UW'(i)};
  endfunction

  assign is_bias_s  = (state_r == FETCH_B);
  assign issue_s    = ((state_r == FETCH_W) || is_bias_s) && !hold_r && (count_r < CW'(MAX_OUT));
  assign accept_s   = issue_s && mem_ready;
  assign pop_s      = mem_rvalid && (count_r != CW'(0));
  assign nxt_s      = next_set(mask_r, u_r);
  assign first_u_s  = lowest_set(mask_r);
  assign req_addr_s = is_bias_s ? bias_addr_in[u_r] : addr_in[u_r];
  assign step_s     = accept_s && (state_r == FETCH_W) && !nxt_s[UW] && (k_r < (ks_r - 8'd1));

  assign mem_req    = issue_s;
  assign mem_addr   = issue_s ? req_addr_s : mem_addr_r;
  assign step       = step_s;
  assign wr_valid   = wr_valid_r;
  assign wr_unit    = wr_unit_r;
  assign wr_is_bias = wr_is_bias_r;
  assign wr_data    = wr_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign err        = err_r;

  // Sequencing FSM: round/unit walk, step pulse hold-off, busy/done/err flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ks_r       <= 8'd0;
      k_r        <= 8'd0;
      mask_r     <= '0;
      u_r        <= '0;
      hold_r     <= 1'b0;
      mem_addr_r <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      hold_r <= step_s;
      done_r <= 1'b0;
      if (issue_s) mem_addr_r <= req_addr_s;
      if (state_r == IDLE && start) err_r <= 1'b0;
      else if (mem_rvalid && count_r == CW'(0)) err_r <= 1'b1;
      case (state_r)
        IDLE: begin
          busy_r <= start;
          if (start) begin
            ks_r   <= kernel_size;
            mask_r <= active_units;
            k_r    <= 8'd0;
            u_r    <= lowest_set(active_units);
            if (kernel_size == 8'd0 || active_units == '0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= FETCH_W;
            end
          end
        end
        FETCH_W: begin
          if (accept_s) begin
            if (nxt_s[UW]) begin
              u_r <= nxt_s[UW-1:0];
            end else begin
              u_r <= first_u_s;
              if (k_r < (ks_r - 8'd1)) k_r <= k_r + 8'd1;
              else state_r <= FETCH_B;
            end
          end
        end
        FETCH_B: begin
          if (accept_s) begin
            if (nxt_s[UW]) u_r <= nxt_s[UW-1:0];
            else state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (count_r == CW'(0)) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Tag FIFO and registered response routing; same-cycle push/pop keeps count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_r       <= '0;
      rptr_r       <= '0;
      count_r      <= '0;
      wr_valid_r   <= 1'b0;
      wr_unit_r    <= '0;
      wr_is_bias_r <= 1'b0;
      wr_data_r    <= '0;
      for (int i = 0; i < MAX_OUT; i++) fifo_r[i] <= '0;
    end else begin
      if (accept_s) begin
        fifo_r[wptr_r] <= {u_r, is_bias_s};
        wptr_r         <= wptr_r + PW'(1);
      end
      if (pop_s) begin
        rptr_r       <= rptr_r + PW'(1);
        wr_data_r    <= mem_rdata;
        wr_unit_r    <= fifo_r[rptr_r][UW:1];
        wr_is_bias_r <= fifo_r[rptr_r][0];
      end
      wr_valid_r <= pop_s;
      count_r    <= count_r + CW'(accept_s) - CW'(pop_s);
    end
  end

endmodule

// File: tb/tb_weight_fetch_seq.sv
// Scoreboard bench for weight_fetch_seq: models the pointer array and an in-order
// memory with configurable latency/backpressure, checks addresses, writes and pulses.
module tb_weight_fetch_seq;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MO = 4;

  typedef struct {
    logic [1:0]  unit;
    logic        bias;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] kernel_size = 8'd0;
  logic [N-1:0] active_units = '0;
  logic [N-1:0][31:0] addr_in, bias_addr_in;
  logic step, mem_req, mem_ready = 1'b1, mem_rvalid = 1'b0;
  logic [31:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic wr_valid, wr_is_bias, busy, done, err;
  logic [1:0] wr_unit;
  logic [DW-1:0] wr_data;

  weight_fetch_seq #(.N_UNITS(N), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk(clk), .rst(rst), .start(start), .kernel_size(kernel_size),
    .active_units(active_units), .addr_in(addr_in), .bias_addr_in(bias_addr_in),
    .step(step), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wr_valid(wr_valid),
    .wr_unit(wr_unit), .wr_is_bias(wr_is_bias), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cfg_ks = 0, ptr_k = 0, lat = 1, cyc = 0;
  logic [N-1:0] cfg_mask = '0;
  bit bp = 1'b0, spur = 1'b0, prev_step = 1'b0, rsp_drv = 1'b0;
  int step_cnt, done_cnt, busy_cnt, req_cnt, acc_cnt, rsp_done, wr_cnt, max_out;
  logic [31:0] exp_addr_q[$];
  wr_t exp_wr_q[$];
  logic [31:0] pend_addr_q[$];
  int pend_due_q[$];

  // Pointer-array layout: each active unit owns ks consecutive words; biases follow.
  function automatic logic [31:0] addr_of(int u, int k, int ks, logic [N-1:0] m);
    int rank = 0;
    for (int i = 0; i < u; i++) if (m[i]) rank++;
    return 32'h100 + 32'(rank * ks + k);
  endfunction

  function automatic logic [31:0] bias_of(int u, int ks, logic [N-1:0] m);
    return 32'h100 + 32'($countones(m) * ks + u);
  endfunction

  // Memory + pointer-array model: observe mid-cycle, drive just after the edge
  always begin
    @(negedge clk);
    if (!rst) begin
      if (prev_step) begin
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL hold_after_step mem_req=%0b want 0", mem_req); end
      end
      prev_step = step;
      if (busy) busy_cnt++;
      if (mem_req) req_cnt++;
      if (mem_req && mem_ready) begin
        acc_cnt++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++; $display("FAIL unexpected_req addr=%h", mem_addr);
        end else begin
          logic [31:0] ea;
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin errors++; $display("FAIL req_addr got %h want %h", mem_addr, ea); end
        end
        pend_addr_q.push_back(mem_addr);
        pend_due_q.push_back(cyc + lat);
        if (acc_cnt - rsp_done > max_out) max_out = acc_cnt - rsp_done;
      end
      if (rsp_drv) rsp_done++;
      if (step) step_cnt++;
      if (wr_valid) begin
        wr_cnt++;
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++; $display("FAIL unexpected_wr unit=%0d data=%h", wr_unit, wr_data);
        end else begin
          wr_t ew;
          ew = exp_wr_q.pop_front();
          if (wr_unit !== ew.unit || wr_is_bias !== ew.bias || wr_data !== ew.data) begin
            errors++;
            $display("FAIL wr got u%0d b%0b %h want u%0d b%0b %h",
                     wr_unit, wr_is_bias, wr_data, ew.unit, ew.bias, ew.data);
          end
        end
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (exp_wr_q.size() != 0 || acc_cnt != rsp_done) begin
          errors++; $display("FAIL done_early pending_wr=%0d want 0", exp_wr_q.size());
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    rsp_drv = 1'b0;
    if (rst) begin
      pend_addr_q.delete(); pend_due_q.delete();
      mem_rvalid = 1'b0; ptr_k = 0; prev_step = 1'b0;
    end else begin
      if (prev_step) ptr_k++;
      mem_ready = bp ? (cyc % 3 == 0) : 1'b1;
      if (spur) begin
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; spur = 1'b0;
      end else if (pend_due_q.size() > 0 && pend_due_q[0] <= cyc) begin
        mem_rvalid = 1'b1;
        mem_rdata  = {24'h0, pend_addr_q[0][7:0]};
        void'(pend_addr_q.pop_front()); void'(pend_due_q.pop_front());
        rsp_drv = 1'b1;
      end else begin
        mem_rvalid = 1'b0;
      end
    end
    for (int u = 0; u < N; u++) begin
      addr_in[u]      = addr_of(u, ptr_k, cfg_ks, cfg_mask);
      bias_addr_in[u] = bias_of(u, cfg_ks, cfg_mask);
    end
  end

  task automatic clear_stats();
    step_cnt = 0; done_cnt = 0; busy_cnt = 0; req_cnt = 0;
    acc_cnt = 0; rsp_done = 0; wr_cnt = 0; max_out = 0;
  endtask

  task automatic expect_seq(int ks, logic [N-1:0] m);
    exp_addr_q.delete(); exp_wr_q.delete();
    if (ks > 0 && m != '0) begin
      for (int k = 0; k < ks; k++)
        for (int u = 0; u < N; u++)
          if (m[u]) begin
            logic [31:0] a;
            a = addr_of(u, k, ks, m);
            exp_addr_q.push_back(a);
            exp_wr_q.push_back('{unit: 2'(u), bias: 1'b0, data: {24'h0, a[7:0]}});
          end
      for (int u = 0; u < N; u++)
        if (m[u]) begin
          logic [31:0] a;
          a = bias_of(u, ks, m);
          exp_addr_q.push_back(a);
          exp_wr_q.push_back('{unit: 2'(u), bias: 1'b1, data: {24'h0, a[7:0]}});
        end
    end
  endtask

  task automatic launch(int ks, logic [N-1:0] m, int l, bit b);
    @(posedge clk); #2;
    cfg_ks = ks; cfg_mask = m; ptr_k = 0; lat = l; bp = b;
    clear_stats();
    expect_seq(ks, m);
    kernel_size = 8'(ks); active_units = m; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic run_seq(int ks, logic [N-1:0] m, int l, bit b, bit mid_start);
    bit did = 1'b0;
    int pc = $countones(m);
    int exp_steps = (ks > 0 && m != '0) ? ks - 1 : 0;
    int exp_wr = (ks > 0 && m != '0) ? (ks + 1) * pc : 0;
    launch(ks, m, l, b);
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      @(posedge clk); #2;
      if (mid_start && !did && acc_cnt >= 2) begin
        kernel_size = 8'd7; active_units = 4'b1111; start = 1'b1; did = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL done_count got %0d want 1", done_cnt); end
    checks++;
    if (step_cnt != exp_steps) begin errors++; $display("FAIL step_count got %0d want %0d", step_cnt, exp_steps); end
    checks++;
    if (wr_cnt != exp_wr || exp_wr_q.size() != 0 || exp_addr_q.size() != 0) begin
      errors++; $display("FAIL write_count got %0d want %0d (left %0d)", wr_cnt, exp_wr, exp_wr_q.size());
    end
    checks++;
    if (max_out > MO) begin errors++; $display("FAIL fifo_depth got %0d want <=%0d", max_out, MO); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_done got %0b want 0", busy); end
  endtask

  task automatic check_quiet(string tag);
    checks++;
    if ({step, mem_req, mem_addr, wr_valid, wr_unit, wr_is_bias, wr_data, busy, done, err} !== '0) begin
      errors++;
      $display("FAIL %s outputs step%0b req%0b addr%h wv%0b wu%0d wb%0b wd%h busy%0b done%0b err%0b want all 0",
               tag, step, mem_req, mem_addr, wr_valid, wr_unit, wr_is_bias, wr_data, busy, done, err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 check_quiet("reset");
    rst = 1'b0;
  endtask

  task automatic test_base();
    run_seq(3, 4'b1011, 1, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_seq(3, 4'b1011, 5, 1'b1, 1'b0);
    run_seq(4, 4'b1111, 9, 1'b0, 1'b0);
    checks++;
    if (max_out != MO) begin errors++; $display("FAIL fifo_fill got %0d want %0d", max_out, MO); end
  endtask

  task automatic test_degenerate();
    run_seq(0, 4'b1011, 1, 1'b0, 1'b0);
    checks++;
    if (req_cnt != 0 || busy_cnt != 1) begin
      errors++; $display("FAIL degen_ks0 req=%0d busy=%0d want 0/1", req_cnt, busy_cnt);
    end
    run_seq(3, 4'b0000, 1, 1'b0, 1'b0);
    checks++;
    if (req_cnt != 0 || busy_cnt != 1) begin
      errors++; $display("FAIL degen_mask0 req=%0d busy=%0d want 0/1", req_cnt, busy_cnt);
    end
  endtask

  task automatic test_start_busy();
    run_seq(3, 4'b1011, 2, 1'b0, 1'b1);
  endtask

  task automatic test_spurious();
    clear_stats();
    @(posedge clk); #2 spur = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", err); end
    checks++;
    if (wr_cnt != 0) begin errors++; $display("FAIL spurious_wr got %0d want 0", wr_cnt); end
    launch(1, 4'b0100, 1, 1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", err); end
    repeat (20) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    launch(3, 4'b1011, 3, 1'b0);
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (acc_cnt >= 5) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_timeout accepts=%0d want 5", acc_cnt); end
    @(posedge clk); #2;
    rst = 1'b1; mem_rvalid = 1'b0;
    exp_addr_q.delete(); exp_wr_q.delete();
    #1 check_quiet("reset_mid");
    @(posedge clk); #3 rst = 1'b0;
    run_seq(1, 4'b0001, 1, 1'b0, 1'b0);
    checks++;
    if (req_cnt != 2) begin errors++; $display("FAIL reset_restart_reqs got %0d want 2", req_cnt); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_base();
    test_backpressure();
    test_degenerate();
    test_start_busy();
    test_spurious();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
